// File: rtl/gemm_sequencer_if.sv
// Command channel of the GEMM sequencer: one tile job per accepted command.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. The issuer holds cmd_valid and every cmd_* field
// stable until that edge. The sequencer raises cmd_ready only while idle and
// ignores cmd_* completely while cmd_ready is low.
interface gemm_sequencer_if #(
    parameter int M_W       = 9,
    parameter int K_W       = 8,
    parameter int ADDR_W    = 12,
    parameter int CORE_ROWS = 2,
    parameter int CORE_COLS = 2
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [M_W-1:0]       cmd_m_rows;
    logic [K_W-1:0]       cmd_k_tiles;
    logic [ADDR_W-1:0]    cmd_w_base;
    logic [ADDR_W-1:0]    cmd_if_base;
    logic [CORE_ROWS-2:0] cmd_if_mux_sel;
    logic [CORE_COLS-2:0] cmd_w_mux_sel;

    modport master (
        output cmd_valid, cmd_m_rows, cmd_k_tiles, cmd_w_base, cmd_if_base,
               cmd_if_mux_sel, cmd_w_mux_sel,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_m_rows, cmd_k_tiles, cmd_w_base, cmd_if_base,
               cmd_if_mux_sel, cmd_w_mux_sel,
        output cmd_ready
    );
endinterface

// File: rtl/gemm_sequencer.sv
// GEMM tile sequencer. For each of k_tiles K-tiles it loads SYS_ROWS weight
// rows, streams m_rows input rows, and waits for the datapath to finish
// accumulating; then it drains the four accumulator banks and pulses done.
// Buffer reads have one cycle of latency, so the datapath strobes are the
// read enables delayed by one register stage.
module gemm_sequencer #(
    parameter int SYS_ROWS  = 16,
    parameter int CORE_ROWS = 2,
    parameter int CORE_COLS = 2,
    parameter int ADDR_W    = 12,
    parameter int M_W       = 9,
    parameter int K_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    gemm_sequencer_if.slave      cmd,
    output logic                 w_rd_en,
    output logic [ADDR_W-1:0]    w_addr,
    output logic                 if_rd_en,
    output logic [ADDR_W-1:0]    if_addr,
    output logic                 wfetch,
    output logic                 if_en,
    output logic                 store,
    output logic                 overwrite,
    output logic [CORE_ROWS-2:0] if_mux_sel,
    output logic [CORE_COLS-2:0] w_mux_sel,
    input  logic                 acc_is_done,
    input  logic [3:0]           acc_empty,
    output logic [3:0]           accums_rd_en,
    output logic                 busy,
    output logic                 done
);

    localparam int SYS_W = (SYS_ROWS > 1) ? $clog2(SYS_ROWS) : 1;
    localparam int CNT_W = (SYS_W > M_W) ? SYS_W : M_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_W   = 3'd1,
        STREAM   = 3'd2,
        WAIT_ACC = 3'd3,
        DRAIN    = 3'd4,
        FINISH   = 3'd5
    } state_t;

    state_t           state;
    logic [M_W-1:0]   m_rows;
    logic [K_W-1:0]   k_tiles;
    logic [K_W-1:0]   tile;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       bank;

    logic [M_W-1:0]   m_last;
    logic [K_W-1:0]   tile_next;
    logic             cmd_zero;

    assign m_last    = m_rows - M_W'(1);
    assign tile_next = tile + K_W'(1);
    assign cmd_zero  = (cmd.cmd_m_rows == '0) || (cmd.cmd_k_tiles == '0);

    assign cmd.cmd_ready = (state == IDLE);
    assign busy          = (state != IDLE);

    // Drain read enable: only the bank currently being served, only while it holds data.
    always_comb begin
        accums_rd_en = 4'b0000;
        if (state == DRAIN && !acc_empty[bank]) begin
            accums_rd_en[bank] = 1'b1;
        end
    end

    // Main sequencer FSM; buffer read enables and addresses are registered with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            m_rows     <= '0;
            k_tiles    <= '0;
            tile       <= '0;
            cnt        <= '0;
            bank       <= '0;
            w_rd_en    <= 1'b0;
            w_addr     <= '0;
            if_rd_en   <= 1'b0;
            if_addr    <= '0;
            if_mux_sel <= '0;
            w_mux_sel  <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid) begin
                        m_rows     <= cmd.cmd_m_rows;
                        k_tiles    <= cmd.cmd_k_tiles;
                        w_addr     <= cmd.cmd_w_base;
                        if_addr    <= cmd.cmd_if_base;
                        if_mux_sel <= cmd.cmd_if_mux_sel;
                        w_mux_sel  <= cmd.cmd_w_mux_sel;
                        tile       <= '0;
                        cnt        <= '0;
                        bank       <= '0;
                        if (cmd_zero) begin
                            // Empty job: nothing to read or accumulate.
                            state <= FINISH;
                        end else begin
                            state   <= LOAD_W;
                            w_rd_en <= 1'b1;
                        end
                    end
                end
                LOAD_W: begin
                    // The pointer runs on across tiles, so tile t starts at base + t*SYS_ROWS.
                    w_addr <= w_addr + ADDR_W'(1);
                    if (cnt == CNT_W'(SYS_ROWS - 1)) begin
                        cnt      <= '0;
                        w_rd_en  <= 1'b0;
                        if_rd_en <= 1'b1;
                        state    <= STREAM;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STREAM: begin
                    if_addr <= if_addr + ADDR_W'(1);
                    if (cnt == CNT_W'(m_last)) begin
                        cnt      <= '0;
                        if_rd_en <= 1'b0;
                        state    <= WAIT_ACC;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_ACC: begin
                    if (acc_is_done) begin
                        tile <= tile_next;
                        if (tile_next == k_tiles) begin
                            bank  <= '0;
                            state <= DRAIN;
                        end else begin
                            w_rd_en <= 1'b1;
                            state   <= LOAD_W;
                        end
                    end
                end
                DRAIN: begin
                    if (acc_empty[bank]) begin
                        if (bank == 2'd3) begin
                            state <= FINISH;
                        end else begin
                            bank <= bank + 2'd1;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Datapath strobes follow the buffer reads by one cycle (read latency);
    // tile 0 overwrites the accumulators, later tiles add into them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wfetch    <= 1'b0;
            if_en     <= 1'b0;
            store     <= 1'b0;
            overwrite <= 1'b0;
        end else begin
            wfetch    <= w_rd_en;
            if_en     <= if_rd_en;
            store     <= if_rd_en;
            overwrite <= if_rd_en && (tile == '0);
        end
    end

endmodule

// File: tb/tb_gemm_sequencer.sv
// Directed bench for gemm_sequencer: the driver pushes the expected read
// addresses, overwrite flags, drain reads and done timing for every command
// into queues; a monitor pops and compares whenever the DUT presents them.
module tb_gemm_sequencer;

  localparam int SYS_ROWS  = 16;
  localparam int CORE_ROWS = 2;
  localparam int CORE_COLS = 2;
  localparam int ADDR_W    = 12;
  localparam int M_W       = 9;
  localparam int K_W       = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  gemm_sequencer_if #(.M_W(M_W), .K_W(K_W), .ADDR_W(ADDR_W),
                      .CORE_ROWS(CORE_ROWS), .CORE_COLS(CORE_COLS)) cmd_bus ();

  logic              w_rd_en, if_rd_en, wfetch, if_en, store, overwrite, busy, done;
  logic [ADDR_W-1:0] w_addr, if_addr;
  logic [0:0]        if_mux_sel, w_mux_sel;
  logic              acc_is_done;
  logic [3:0]        acc_empty, accums_rd_en;

  gemm_sequencer #(.SYS_ROWS(SYS_ROWS), .CORE_ROWS(CORE_ROWS), .CORE_COLS(CORE_COLS),
                   .ADDR_W(ADDR_W), .M_W(M_W), .K_W(K_W)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_bus),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .if_rd_en(if_rd_en), .if_addr(if_addr),
    .wfetch(wfetch), .if_en(if_en), .store(store), .overwrite(overwrite),
    .if_mux_sel(if_mux_sel), .w_mux_sel(w_mux_sel),
    .acc_is_done(acc_is_done), .acc_empty(acc_empty), .accums_rd_en(accums_rd_en),
    .busy(busy), .done(done)
  );

  // scoreboard state
  logic [ADDR_W-1:0] w_exp_q[$];
  logic [ADDR_W-1:0] if_exp_q[$];
  logic              ow_exp_q[$];
  logic [3:0]        acc_exp_q[$];
  int                done_exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_target = 0;
  logic exp_ifs = 1'b0;
  logic exp_ws = 1'b0;
  bit spurious_en = 1'b0;

  int acc_cnt[4];
  logic [3:0] rd_s;
  logic pw = 1'b0;
  logic pi = 1'b0;
  logic prev_store = 1'b0;
  logic prev_w = 1'b0;
  int cd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: DUT output with no expected entry (cycle %0d)", name, cyc);
  endtask

  function automatic void upd_empty();
    for (int b = 0; b < 4; b++) acc_empty[b] = (acc_cnt[b] == 0);
  endfunction

  // accumulator bank model: a read granted at a clock edge removes one entry
  initial begin
    forever begin
      @(negedge clk);
      rd_s = accums_rd_en;
      @(posedge clk);
      #1;
      for (int b = 0; b < 4; b++) if (rd_s[b] && acc_cnt[b] > 0) acc_cnt[b]--;
      upd_empty();
    end
  end

  // datapath responder: acc_is_done a few cycles after the last store of a tile,
  // plus optional stray pulses while weights load (must be ignored)
  initial begin
    acc_is_done = 1'b0;
    forever begin
      @(negedge clk);
      acc_is_done = 1'b0;
      if (rst) begin
        cd = 0;
        prev_store = 1'b0;
        prev_w = 1'b0;
      end else begin
        if (cd == 1) acc_is_done = 1'b1;
        if (cd != 0) cd--;
        if (prev_store && !store) cd = 3;
        if (spurious_en && w_rd_en && !prev_w) acc_is_done = 1'b1;
        prev_store = store;
        prev_w = w_rd_en;
      end
    end
  end

  // monitor: compare everything the DUT presents against the queues
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pw = 1'b0;
        pi = 1'b0;
      end else begin
        if (wfetch || pw) check("wfetch_lag", wfetch, pw);
        if (if_en || pi) check("if_en_lag", if_en, pi);
        if (store || pi) check("store_lag", store, pi);
        if (w_rd_en) begin
          if (w_exp_q.size() == 0) unexpected("w_rd_en");
          else check("w_addr", w_addr, w_exp_q.pop_front());
        end
        if (if_rd_en) begin
          if (if_exp_q.size() == 0) unexpected("if_rd_en");
          else check("if_addr", if_addr, if_exp_q.pop_front());
        end
        if (store) begin
          if (ow_exp_q.size() == 0) unexpected("store");
          else check("overwrite", overwrite, ow_exp_q.pop_front());
        end else if (overwrite) begin
          check("overwrite_without_store", overwrite, 1'b0);
        end
        if (accums_rd_en != 4'b0000) begin
          if (acc_exp_q.size() == 0) unexpected("accums_rd_en");
          else check("accums_rd_en", accums_rd_en, acc_exp_q.pop_front());
        end
        if (done) begin
          check("done_busy", busy, 1'b0);
          if (done_exp_q.size() == 0) unexpected("done");
          else begin
            int e;
            e = done_exp_q.pop_front();
            if (e >= 0) check("done_cycle", cyc, e);
          end
          done_cnt++;
        end
        pw = w_rd_en;
        pi = if_rd_en;
      end
    end
  end

  // driver: push expectations, then hand the command over
  task automatic issue(input int m, input int k, input logic [ADDR_W-1:0] wb,
                       input logic [ADDR_W-1:0] ib, input logic ifs, input logic ws,
                       input int f0, input int f1, input int f2, input int f3, input bit junk);
    logic [ADDR_W-1:0] a;
    int fill[4];
    int acc_cyc;
    fill = '{f0, f1, f2, f3};
    if (m != 0 && k != 0) begin
      for (int t = 0; t < k; t++)
        for (int i = 0; i < SYS_ROWS; i++) begin
          a = wb + ADDR_W'(t * SYS_ROWS + i);
          w_exp_q.push_back(a);
        end
      for (int t = 0; t < k; t++)
        for (int j = 0; j < m; j++) begin
          a = ib + ADDR_W'(t * m + j);
          if_exp_q.push_back(a);
          ow_exp_q.push_back(t == 0);
        end
      for (int b = 0; b < 4; b++)
        for (int n = 0; n < fill[b]; n++) acc_exp_q.push_back(4'(1 << b));
    end
    acc_cnt = fill;
    upd_empty();
    @(negedge clk);
    check("cmd_ready_idle", cmd_bus.cmd_ready, 1'b1);
    cmd_bus.cmd_m_rows     = M_W'(m);
    cmd_bus.cmd_k_tiles    = K_W'(k);
    cmd_bus.cmd_w_base     = wb;
    cmd_bus.cmd_if_base    = ib;
    cmd_bus.cmd_if_mux_sel = ifs;
    cmd_bus.cmd_w_mux_sel  = ws;
    cmd_bus.cmd_valid      = 1'b1;
    acc_cyc = cyc;
    if (m == 0 || k == 0) done_exp_q.push_back(acc_cyc + 2);
    else done_exp_q.push_back(-1);
    done_target++;
    exp_ifs = ifs;
    exp_ws = ws;
    @(negedge clk);
    check("busy_after_accept", {busy, cmd_bus.cmd_ready}, 2'b10);
    if (junk) begin
      for (int i = 0; i < 3; i++) begin
        cmd_bus.cmd_m_rows  = M_W'($urandom_range(1, 300));
        cmd_bus.cmd_k_tiles = K_W'($urandom_range(1, 200));
        cmd_bus.cmd_w_base  = ADDR_W'($urandom_range(0, 4095));
        cmd_bus.cmd_if_base = ADDR_W'($urandom_range(0, 4095));
        cmd_bus.cmd_if_mux_sel = ~ifs;
        cmd_bus.cmd_w_mux_sel  = ~ws;
        @(negedge clk);
      end
    end
    cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt < done_target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", done_cnt >= done_target, 1'b1);
    @(negedge clk);
    check("w_q_drained", w_exp_q.size(), 0);
    check("if_q_drained", if_exp_q.size(), 0);
    check("ow_q_drained", ow_exp_q.size(), 0);
    check("acc_q_drained", acc_exp_q.size(), 0);
    check("mux_sel_held", {if_mux_sel, w_mux_sel}, {exp_ifs, exp_ws});
    check("idle_after_done", {busy, cmd_bus.cmd_ready}, 2'b01);
  endtask

  // global time limit
  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  // directed test sequence
  initial begin
    int n;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_m_rows = '0;
    cmd_bus.cmd_k_tiles = '0;
    cmd_bus.cmd_w_base = '0;
    cmd_bus.cmd_if_base = '0;
    cmd_bus.cmd_if_mux_sel = '0;
    cmd_bus.cmd_w_mux_sel = '0;
    acc_cnt = '{0, 0, 0, 0};
    upd_empty();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {w_rd_en, if_rd_en, wfetch, if_en, store, overwrite, busy, done,
                            accums_rd_en, if_mux_sel, w_mux_sel, w_addr, if_addr}, '0);
    check("reset_cmd_ready", cmd_bus.cmd_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // single tile, four input rows
    issue(4, 1, 12'h000, 12'h100, 1'b1, 1'b0, 2, 1, 0, 1, 1'b0);
    wait_done();

    // three tiles with junk on cmd_* while busy and stray acc_is_done pulses
    spurious_en = 1'b1;
    issue(2, 3, 12'h000, 12'h200, 1'b0, 1'b1, 1, 0, 0, 0, 1'b1);
    wait_done();
    spurious_en = 1'b0;

    // drain with banks 1 and 3 empty at entry
    issue(1, 1, 12'h040, 12'h300, 1'b1, 1'b1, 2, 0, 3, 0, 1'b0);
    wait_done();

    // empty jobs: no reads, done two cycles after acceptance
    issue(5, 0, 12'h010, 12'h020, 1'b0, 1'b0, 1, 1, 1, 1, 1'b0);
    wait_done();
    issue(0, 2, 12'h010, 12'h020, 1'b1, 1'b0, 1, 1, 1, 1, 1'b0);
    wait_done();

    // address wrap on both buffers
    issue(3, 1, 12'hFF8, 12'hFFE, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0);
    wait_done();

    // reset in the middle of STREAM
    issue(4, 2, 12'h100, 12'h400, 1'b1, 1'b1, 1, 1, 1, 1, 1'b0);
    n = 0;
    while (!if_rd_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_stream", if_rd_en, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_reset_outputs", {w_rd_en, if_rd_en, wfetch, if_en, store, overwrite, busy, done,
                                   accums_rd_en, if_mux_sel, w_mux_sel, w_addr, if_addr}, '0);
    check("midrun_reset_cmd_ready", cmd_bus.cmd_ready, 1'b1);
    w_exp_q.delete();
    if_exp_q.delete();
    ow_exp_q.delete();
    acc_exp_q.delete();
    done_exp_q.delete();
    done_target--;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // first command after reset starts again at tile 0 with overwrite
    issue(2, 1, 12'h080, 12'h500, 1'b0, 1'b0, 0, 1, 0, 0, 1'b0);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gemm_sequencer.md
GEMM_SEQUENCER -- requirements
Module: gemm_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  SYS_ROWS, 16, systolic rows; length of one weight load in cycles.
  CORE_ROWS, 2, core rows; if_mux_sel width is CORE_ROWS-1.
  CORE_COLS, 2, core cols; w_mux_sel width is CORE_COLS-1.
  ADDR_W, 12, buffer address width.
  M_W, 9, row-count field width.
  K_W, 8, K-tile-count field width.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
  clk in 1 sole clock, rising edge.
  rst in 1 reset, asynchronous, active-high.
  cmd_valid in 1 command offered.
  cmd_ready out 1 command accepted when both high.
  cmd_m_rows in M_W input rows per K-tile.
  cmd_k_tiles in K_W K-tiles to accumulate.
  cmd_w_base / cmd_if_base in ADDR_W weight / input buffer base addresses.
  cmd_if_mux_sel in CORE_ROWS-1 datapath row mode; cmd_w_mux_sel in CORE_COLS-1 column mode.
  w_rd_en out 1, w_addr out ADDR_W: weight buffer read.
  if_rd_en out 1, if_addr out ADDR_W: input buffer read.
  wfetch out 1, if_en out 1: datapath valid strobes.
  store out 1, overwrite out 1: accumulator controls.
  if_mux_sel out CORE_ROWS-1, w_mux_sel out CORE_COLS-1: datapath mode.
  acc_is_done in 1 datapath pulse: last partial sum of current tile accumulated.
  acc_empty in 4 accumulator bank empty flags.
  accums_rd_en out 4 accumulator bank read enables.
  busy out 1 high in every state except IDLE; done out 1 one-cycle completion pulse.

Function
REQ-003 FSM states SHALL be IDLE, LOAD_W, STREAM, WAIT_ACC, DRAIN, FINISH.
REQ-004 cmd_ready SHALL equal (state==IDLE); an accepted command SHALL latch all cmd_* fields, and the next state SHALL be LOAD_W.
REQ-005 A command with cmd_m_rows==0 or cmd_k_tiles==0 SHALL go IDLE->FINISH with no buffer reads, strobes or accumulator reads.
REQ-006 if_mux_sel/w_mux_sel SHALL drive the latched values from the cycle after acceptance until the cycle after done, then hold the last value.
REQ-007 LOAD_W SHALL assert w_rd_en for exactly SYS_ROWS consecutive cycles; w_addr = w_base + tile*SYS_ROWS + i for i=0..SYS_ROWS-1; then the next state SHALL be STREAM.
REQ-008 STREAM SHALL assert if_rd_en for exactly m_rows cycles; if_addr = if_base + tile*m_rows + j; then the next state SHALL be WAIT_ACC.
REQ-009 Buffer read latency SHALL be 1 cycle: wfetch, if_en, store and overwrite SHALL be registered copies of the corresponding read enable.
REQ-010 store SHALL equal delayed if_rd_en; overwrite SHALL equal delayed if_rd_en AND (tile==0), so tile 0 overwrites and later tiles accumulate.
REQ-011 Address arithmetic SHALL be modulo 2^ADDR_W (silent wrap).
REQ-012 WAIT_ACC SHALL hold until acc_is_done, then increment tile; go to DRAIN if tile+1==k_tiles, else to LOAD_W.
REQ-013 acc_is_done outside WAIT_ACC SHALL be ignored.
REQ-014 DRAIN SHALL serve banks 0..3 in order: accums_rd_en[b] = !acc_empty[b] for the current bank b; otherwise 0; at most one bit set.
REQ-015 DRAIN SHALL advance b when acc_empty[b]==1; when bank 3 is empty, the next state SHALL be FINISH.
REQ-016 FINISH SHALL last one cycle with done=1, then go to IDLE; a new command SHALL be accepted no earlier than the following cycle.
REQ-017 cmd_* changes while busy SHALL have no effect.

Reset
REQ-018 rst high SHALL force IDLE immediately (asynchronously), including mid-operation.
REQ-019 While rst is high, every output SHALL be 0 except cmd_ready=1 and the mux selects, which SHALL be 0; tile, bank and counters SHALL be cleared.
REQ-020 After rst deasserts, the first command SHALL behave as if no prior command existed.

Verification
REQ-021 m_rows=4, k_tiles=1, w_base=0, if_base=0x100 -> w_addr 0..15, wfetch 16 cycles lagging 1; if_addr 0x100..0x103; overwrite=store=1 for 4 cycles; drain; done one cycle.
REQ-022 k_tiles=3, m_rows=2 -> overwrite only in tile 0; store in all 3 tiles; w_addr 0..47; if_addr base..base+5; exactly 3 LOAD_W phases.
REQ-023 acc_empty=4'b1010 at DRAIN entry, bank0 empties after 2 reads -> accums_rd_en 0001 x2; bank1 skipped; bank2 read until empty; then FINISH.
REQ-024 cmd_k_tiles=0 -> done 2 cycles after acceptance; w_rd_en, if_rd_en and accums_rd_en never set.
REQ-025 rst pulsed during STREAM -> outputs 0 within the reset cycle; cmd_ready=1; next command restarts at tile 0 with overwrite.
REQ-026 w_base=0xFF8, SYS_ROWS=16 -> w_addr 0xFF8..0xFFF then wraps to 0x000..0x007.
